// File: rtl/noise_chan_gen2_if.sv
// Register-write and LFO strobe bundle between the APU bus decode and the noise channel.
interface noise_chan_gen2_if #(
  parameter int LC_W = 8
);
  logic [7:0]      DB;
  logic            W_CTRL;
  logic            W_MODE;
  logic            W_PLO;
  logic            W_PHI;
  logic            W_LEN;
  logic [LC_W-1:0] LC_VAL;
  logic            ENA;
  logic            nLFO1;
  logic            nLFO2;
  logic [3:0]      RND_OUT;
  logic            LC_ACT;

  modport master (
    output DB, W_CTRL, W_MODE, W_PLO, W_PHI, W_LEN, LC_VAL, ENA, nLFO1, nLFO2,
    input  RND_OUT, LC_ACT
  );

  modport slave (
    input  DB, W_CTRL, W_MODE, W_PLO, W_PHI, W_LEN, LC_VAL, ENA, nLFO1, nLFO2,
    output RND_OUT, LC_ACT
  );
endinterface

// File: rtl/noise_chan_gen2.sv
// APU noise channel, second generation: LFSR noise source with period timer,
// envelope unit and length counter. Output is a 4-bit sample for the mixer.
module noise_chan_gen2 #(
  parameter int LFSR_W    = 15,
  parameter int TAP_LONG  = 1,
  parameter int TAP_SHORT = 6,
  parameter int PERIOD_W  = 11,
  parameter int LC_W      = 8
) (
  input  logic              ACLK,
  input  logic              RES,
  noise_chan_gen2_if.slave  bus
);

  localparam int HI_W = PERIOD_W - 8;

  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [PERIOD_W-1:0] tcnt_q, tcnt_d;
  logic [PERIOD_W-1:0] per_q, per_d;
  logic [PERIOD_W-1:0] reload;
  logic                halt_q, halt_d;
  logic                const_q, const_d;
  logic [3:0]          vol_q, vol_d;
  logic                short_q, short_d;
  logic                direct_q, direct_d;
  logic [3:0]          idx_q, idx_d;
  logic                start_q, start_d;
  logic [3:0]          decay_q, decay_d;
  logic [3:0]          div_q, div_d;
  logic [LC_W-1:0]     lc_q, lc_d;
  logic [3:0]          vol_sel;

  // Table periods minus one, i.e. the value the timer reloads with.
  function automatic logic [PERIOD_W-1:0] table_reload(input logic [3:0] idx);
    logic [10:0] r;
    case (idx)
      4'd0:    r = 11'd1;
      4'd1:    r = 11'd3;
      4'd2:    r = 11'd7;
      4'd3:    r = 11'd15;
      4'd4:    r = 11'd31;
      4'd5:    r = 11'd47;
      4'd6:    r = 11'd63;
      4'd7:    r = 11'd79;
      4'd8:    r = 11'd100;
      4'd9:    r = 11'd126;
      4'd10:   r = 11'd189;
      4'd11:   r = 11'd253;
      4'd12:   r = 11'd380;
      4'd13:   r = 11'd507;
      4'd14:   r = 11'd1016;
      default: r = 11'd2033;
    endcase
    return PERIOD_W'(r);
  endfunction

  // Period timer and LFSR step; direct mode reloads with P so the period is P+1.
  always_comb begin
    reload = direct_q ? per_q : table_reload(idx_q);
    tcnt_d = tcnt_q - PERIOD_W'(1);
    lfsr_d = lfsr_q;
    if (tcnt_q == '0) begin
      tcnt_d = reload;
      if (lfsr_q == '0) begin
        lfsr_d = LFSR_W'(1);
      end else begin
        lfsr_d = {lfsr_q[0] ^ (short_q ? lfsr_q[TAP_SHORT] : lfsr_q[TAP_LONG]),
                  lfsr_q[LFSR_W-1:1]};
      end
    end
  end

  // Envelope divider/decay on quarter-frame; a length write arms a restart.
  always_comb begin
    start_d = start_q;
    decay_d = decay_q;
    div_d   = div_q;
    if (!bus.nLFO1) begin
      if (start_q) begin
        start_d = 1'b0;
        decay_d = 4'hF;
        div_d   = vol_q;
      end else if (div_q == 4'd0) begin
        div_d = vol_q;
        if (decay_q != 4'd0) begin
          decay_d = decay_q - 4'd1;
        end else if (halt_q) begin
          decay_d = 4'hF;
        end
      end else begin
        div_d = div_q - 4'd1;
      end
    end
    if (bus.W_LEN) begin
      start_d = 1'b1;
    end
  end

  // Length counter: disable clears, load beats a coincident half-frame decrement.
  always_comb begin
    lc_d = lc_q;
    if (!bus.ENA) begin
      lc_d = '0;
    end else if (bus.W_LEN) begin
      lc_d = bus.LC_VAL;
    end else if (!bus.nLFO2 && (lc_q != '0) && !halt_q) begin
      lc_d = lc_q - LC_W'(1);
    end
  end

  // Register-file writes; each strobe only touches its own fields.
  always_comb begin
    halt_d   = halt_q;
    const_d  = const_q;
    vol_d    = vol_q;
    short_d  = short_q;
    direct_d = direct_q;
    idx_d    = idx_q;
    per_d    = per_q;
    if (bus.W_CTRL) begin
      halt_d  = bus.DB[5];
      const_d = bus.DB[4];
      vol_d   = bus.DB[3:0];
    end
    if (bus.W_MODE) begin
      short_d  = bus.DB[7];
      direct_d = bus.DB[6];
      idx_d    = bus.DB[3:0];
    end
    if (bus.W_PLO) begin
      per_d[7:0] = bus.DB;
    end
    if (bus.W_PHI) begin
      per_d[PERIOD_W-1:8] = HI_W'(bus.DB);
    end
  end

  // State registers with synchronous reset; LFSR seeds to 1.
  always_ff @(posedge ACLK) begin
    if (RES) begin
      lfsr_q   <= LFSR_W'(1);
      tcnt_q   <= '0;
      per_q    <= '0;
      halt_q   <= 1'b0;
      const_q  <= 1'b0;
      vol_q    <= '0;
      short_q  <= 1'b0;
      direct_q <= 1'b0;
      idx_q    <= '0;
      start_q  <= 1'b0;
      decay_q  <= '0;
      div_q    <= '0;
      lc_q     <= '0;
    end else begin
      lfsr_q   <= lfsr_d;
      tcnt_q   <= tcnt_d;
      per_q    <= per_d;
      halt_q   <= halt_d;
      const_q  <= const_d;
      vol_q    <= vol_d;
      short_q  <= short_d;
      direct_q <= direct_d;
      idx_q    <= idx_d;
      start_q  <= start_d;
      decay_q  <= decay_d;
      div_q    <= div_d;
      lc_q     <= lc_d;
    end
  end

  assign vol_sel     = const_q ? vol_q : decay_q;
  assign bus.RND_OUT = (!lfsr_q[0] && (lc_q != '0)) ? vol_sel : 4'd0;
  assign bus.LC_ACT  = (lc_q != '0);

endmodule

// File: tb/tb_noise_chan_gen2.sv
// Bench for noise_chan_gen2: cycle reference model, period vector table,
// hand sequences for length/envelope/reset corners, then random traffic.
module tb_noise_chan_gen2;
  localparam int LFSR_W = 15, TAP_LONG = 1, TAP_SHORT = 6, PERIOD_W = 11, LC_W = 8;
  localparam int WC = 0, WM = 1, WPL = 2, WPH = 3, WL = 4;

  logic ACLK = 1'b0;
  logic RES;
  always #5 ACLK = ~ACLK;

  noise_chan_gen2_if #(.LC_W(LC_W)) bus ();

  noise_chan_gen2 #(
    .LFSR_W(LFSR_W), .TAP_LONG(TAP_LONG), .TAP_SHORT(TAP_SHORT),
    .PERIOD_W(PERIOD_W), .LC_W(LC_W)
  ) dut (
    .ACLK(ACLK), .RES(RES), .bus(bus)
  );

  int total = 0, bad = 0, prints = 0;

  int unsigned PTAB[16] = '{2, 4, 8, 16, 32, 48, 64, 80, 101, 127, 190, 254, 381, 508, 1017, 2034};

  // Reference state, kept as plain integers.
  int unsigned m_lfsr, m_tcnt, m_P, m_idx, m_V, m_decay, m_div, m_lc;
  bit m_short, m_direct, m_halt, m_const, m_start;

  typedef struct {
    logic [7:0] mode_db;
    logic [7:0] plo;
    logic [7:0] phi;
    int         per;
  } vec_t;
  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (prints < 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      prints++;
    end
  endtask

  function automatic int unsigned lfsr_next(input int unsigned l, input bit sh);
    int unsigned tap, fb;
    if (l == 0) return 1;
    tap = sh ? TAP_SHORT : TAP_LONG;
    fb  = (l ^ (l >> tap)) & 1;
    return (l >> 1) | (fb << (LFSR_W - 1));
  endfunction

  function automatic int model_period(input int unsigned s, input bit sh);
    int unsigned l = s;
    int n = 0;
    do begin
      l = lfsr_next(l, sh);
      n++;
    end while (l != s && n < 40000);
    return n;
  endfunction

  task automatic model_reset();
    m_lfsr = 1; m_tcnt = 0; m_P = 0; m_idx = 0; m_V = 0; m_decay = 0; m_div = 0; m_lc = 0;
    m_short = 0; m_direct = 0; m_halt = 0; m_const = 0; m_start = 0;
  endtask

  // One APU cycle: events use the old register values, writes land afterwards.
  task automatic model_clk();
    int unsigned db;
    if (RES) begin
      model_reset();
      return;
    end
    db = 32'(bus.DB);
    if (m_tcnt == 0) begin
      m_tcnt = (m_direct ? m_P + 1 : PTAB[m_idx]) - 1;
      m_lfsr = lfsr_next(m_lfsr, m_short);
    end else begin
      m_tcnt--;
    end
    if (!bus.nLFO1) begin
      if (m_start) begin
        m_start = 0; m_decay = 15; m_div = m_V;
      end else if (m_div == 0) begin
        m_div = m_V;
        if (m_decay > 0) m_decay--;
        else if (m_halt) m_decay = 15;
      end else begin
        m_div--;
      end
    end
    if (!bus.ENA) m_lc = 0;
    else if (bus.W_LEN) m_lc = 32'(bus.LC_VAL);
    else if (!bus.nLFO2 && m_lc != 0 && !m_halt) m_lc--;
    if (bus.W_LEN) m_start = 1;
    if (bus.W_CTRL) begin m_halt = db[5]; m_const = db[4]; m_V = db & 15; end
    if (bus.W_MODE) begin m_short = db[7]; m_direct = db[6]; m_idx = db & 15; end
    if (bus.W_PLO) m_P = (m_P & ~32'hFF) | db;
    if (bus.W_PHI) m_P = (m_P & 32'hFF) | ((db & ((1 << (PERIOD_W - 8)) - 1)) << 8);
  endtask

  function automatic int unsigned exp_rnd();
    if ((m_lfsr & 1) == 0 && m_lc != 0) return m_const ? m_V : m_decay;
    return 0;
  endfunction

  task automatic cyc();
    @(posedge ACLK);
    model_clk();
    #1;
    check("rnd_out", 32'(bus.RND_OUT), exp_rnd());
    check("lc_act", 32'(bus.LC_ACT), 32'(m_lc != 0));
    check("lfsr", 32'(dut.lfsr_q), m_lfsr);
  endtask

  task automatic idle();
    bus.DB = 8'h00; bus.W_CTRL = 0; bus.W_MODE = 0; bus.W_PLO = 0; bus.W_PHI = 0;
    bus.W_LEN = 0; bus.nLFO1 = 1; bus.nLFO2 = 1;
  endtask

  task automatic wr(input int which, input logic [7:0] d);
    bus.DB = d;
    case (which)
      WC:      bus.W_CTRL = 1;
      WM:      bus.W_MODE = 1;
      WPL:     bus.W_PLO = 1;
      WPH:     bus.W_PHI = 1;
      default: bus.W_LEN = 1;
    endcase
    cyc();
    idle();
  endtask

  // Cycles until the DUT's LFSR next changes (bounded).
  task automatic wait_step(output int n);
    logic [LFSR_W-1:0] p;
    p = dut.lfsr_q;
    n = 0;
    do begin
      cyc();
      n++;
    end while (dut.lfsr_q == p && n < 5000);
    if (n >= 5000) check("step_timeout", 32'(n), 0);
  endtask

  task automatic pulse1();
    bus.nLFO1 = 0; cyc(); bus.nLFO1 = 1; cyc();
  endtask

  task automatic pulse2();
    bus.nLFO2 = 0; cyc(); bus.nLFO2 = 1; cyc();
  endtask

  initial begin
    int n, early, z, p, e;
    int unsigned s0;
    logic [7:0] d;

    for (int i = 0; i < 16; i++) vecs[i] = '{8'(i), 8'h00, 8'h00, int'(PTAB[i])};
    vecs[16] = '{8'h40, 8'h05, 8'h00, 6};
    vecs[17] = '{8'h40, 8'h00, 8'h00, 1};
    vecs[18] = '{8'h40, 8'hFF, 8'h01, 512};
    vecs[19] = '{8'hC0, 8'h03, 8'h00, 4};

    model_reset();
    idle();
    bus.ENA = 0; bus.LC_VAL = '0;
    RES = 1;

    // Reset and first step
    repeat (3) cyc();
    check("reset_rnd", 32'(bus.RND_OUT), 0);
    check("reset_lcact", 32'(bus.LC_ACT), 0);
    check("reset_lfsr", 32'(dut.lfsr_q), 32'h0001);
    check("reset_tcnt", 32'(dut.tcnt_q), 0);
    RES = 0;
    cyc();
    check("first_step", 32'(dut.lfsr_q), 32'h4000);

    // Long mode, table index 0
    bus.ENA = 1;
    wr(WC, 8'h1F);
    wr(WM, 8'h00);
    bus.LC_VAL = 8'd10;
    wr(WL, 8'h00);
    wait_step(n);
    wait_step(n);
    check("long_per", 32'(n), 2);
    check("rnd_15_or_0", 32'(bus.RND_OUT == 0 || bus.RND_OUT == 15), 1);
    s0 = m_lfsr;
    early = 0;
    for (int i = 1; i <= 32767; i++) begin
      wait_step(n);
      if (i < 32767 && dut.lfsr_q == LFSR_W'(s0)) early++;
    end
    check("long_early_repeat", 32'(early), 0);
    check("long_full_cycle", 32'(dut.lfsr_q), s0);

    // Short mode
    wr(WM, 8'h80);
    z = 0;
    for (int i = 0; i < 200; i++) begin
      wait_step(n);
      if (dut.lfsr_q == '0) z++;
    end
    check("short_nozero", 32'(z), 0);
    s0 = 32'(dut.lfsr_q);
    p = 0;
    do begin
      wait_step(n);
      p++;
    end while (dut.lfsr_q != LFSR_W'(s0) && p < 200);
    check("short_period", 32'(p), 32'(model_period(s0, 1'b1)));
    check("short_period_31_93", 32'(p == 31 || p == 93), 1);

    // Length counter
    wr(WC, 8'h1F);
    bus.LC_VAL = 8'd3;
    wr(WL, 8'h00);
    check("lc_load", 32'(dut.lc_q), 3);
    for (int k = 1; k <= 3; k++) begin
      pulse2();
      check("lc_dec", 32'(dut.lc_q), 32'(3 - k));
      check("lc_act_dec", 32'(bus.LC_ACT), 32'(k < 3));
    end
    check("lc_zero_rnd", 32'(bus.RND_OUT), 0);
    pulse2();
    check("lc_stays_zero", 32'(dut.lc_q), 0);
    bus.LC_VAL = 8'd7;
    bus.W_LEN = 1; bus.nLFO2 = 0;
    cyc();
    idle();
    check("lc_load_beats_dec", 32'(dut.lc_q), 7);
    wr(WC, 8'h3F);
    pulse2();
    check("lc_halt", 32'(dut.lc_q), 7);
    bus.ENA = 0;
    cyc();
    check("lc_ena_off", 32'(bus.LC_ACT), 0);
    bus.LC_VAL = 8'd5;
    wr(WL, 8'h00);
    check("lc_load_blocked", 32'(dut.lc_q), 0);
    bus.ENA = 1;

    // Envelope, no loop then loop
    wr(WC, 8'h02);
    bus.LC_VAL = 8'd100;
    wr(WL, 8'h00);
    for (int k = 1; k <= 50; k++) begin
      pulse1();
      e = 15 - (k - 1) / 3;
      if (e < 0) e = 0;
      check("env_decay", 32'(dut.decay_q), 32'(e));
    end
    wr(WC, 8'h22);
    wr(WL, 8'h00);
    for (int k = 1; k <= 52; k++) begin
      pulse1();
      check("env_loop", 32'(dut.decay_q), 32'(15 - ((k - 1) / 3) % 16));
    end

    // Period vector table
    wr(WC, 8'h1F);
    for (int i = 0; i < 20; i++) begin
      wr(WPL, vecs[i].plo);
      wr(WPH, vecs[i].phi);
      wr(WM, vecs[i].mode_db);
      wait_step(n);
      wait_step(n);
      check($sformatf("period_%0d", i), 32'(n), 32'(vecs[i].per));
    end

    // Direct period change mid-count
    wr(WPH, 8'h00);
    wr(WPL, 8'h05);
    wr(WM, 8'h40);
    wait_step(n);
    wait_step(n);
    check("direct_p5", 32'(n), 6);
    cyc(); cyc();
    wr(WPL, 8'h01);
    wait_step(n);
    check("mid_change_old", 32'(n + 3), 6);
    wait_step(n);
    check("mid_change_new", 32'(n), 2);

    // Reset mid-run with strobes active
    RES = 1;
    bus.W_LEN = 1; bus.W_CTRL = 1; bus.W_MODE = 1; bus.DB = 8'hFF; bus.nLFO1 = 0; bus.nLFO2 = 0;
    cyc();
    idle();
    check("res_lfsr", 32'(dut.lfsr_q), 1);
    check("res_lc", 32'(dut.lc_q), 0);
    check("res_decay", 32'(dut.decay_q), 0);
    check("res_tcnt", 32'(dut.tcnt_q), 0);
    check("res_start", 32'(dut.start_q), 0);
    check("res_rnd", 32'(bus.RND_OUT), 0);
    check("res_lcact", 32'(bus.LC_ACT), 0);
    RES = 0;

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      RES = ($urandom % 500) == 0;
      d = 8'($urandom);
      bus.W_CTRL = ($urandom % 16) == 0;
      bus.W_MODE = ($urandom % 16) == 0;
      bus.W_PLO  = ($urandom % 16) == 0;
      bus.W_PHI  = ($urandom % 16) == 0;
      bus.W_LEN  = ($urandom % 16) == 0;
      if (bus.W_MODE) d = d & 8'hC3;
      if (bus.W_PHI) d = d & 8'h01;
      bus.DB = d;
      bus.LC_VAL = 8'($urandom);
      bus.ENA = ($urandom % 40) != 0;
      bus.nLFO1 = ($urandom % 8) != 0;
      bus.nLFO2 = ($urandom % 8) != 0;
      cyc();
    end
    RES = 0;
    idle();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noise_chan_gen2.md
# noise_chan_gen2

Parametrised second-generation APU noise channel: LFSR noise source, period timer, envelope unit and built-in length counter in one block. It adds selectable LFSR width and taps, plus a direct programmable period mode next to the classic 16-entry period table. It is clocked by ACLK, is driven by the APU register-write strobes and the frame-counter LFO pulses, and its 4-bit output goes to the AUX/DAC mixer.

## Interface
Parameters:
- LFSR_W, 15: shift-register width (≥ 8).
- TAP_LONG, 1: feedback tap, long mode.
- TAP_SHORT, 6: feedback tap, short mode (< LFSR_W).
- PERIOD_W, 11: timer width (≥ 11).
- LC_W, 8: length counter width.

Ports:
- ACLK  in  1  clock; one cycle = one APU cycle.
- RES  in  1  synchronous, active-high reset.
- DB  in  8  write data; sampled when any write strobe is high.
- W_CTRL  in  1  ctrl write: DB[5] halt/loop, DB[4] constant, DB[3:0] V.
- W_MODE  in  1  mode write: DB[7] short, DB[6] direct, DB[3:0] table index.
- W_PLO  in  1  direct period bits [7:0] ← DB.
- W_PHI  in  1  direct period bits [PERIOD_W-1:8] ← DB low bits.
- W_LEN  in  1  length load (lc_val) and envelope restart.
- LC_VAL  in  LC_W  decoded length from the existing length PLA.
- ENA  in  1  length enable ($4015 bit).
- nLFO1  in  1  active-low quarter-frame pulse, one cycle.
- nLFO2  in  1  active-low half-frame pulse, one cycle.
- RND_OUT  out  4  channel sample.
- LC_ACT  out  1  length counter ≠ 0 (status read).

## Operation
- **Timer:** down-counter `tcnt` runs every cycle.
  - When `tcnt == 0`: reload with `per − 1` and step the LFSR. Otherwise decrement.
  - Table mode (direct = 0): `per` = table[index]. Table, in ACLK units: 2,4,8,16,32,48,64,80,101,127,190,254,381,508,1017,2034.
  - Direct mode: `per` = P + 1. P = 0 steps every cycle.
  - Period and mode writes take effect at the next reload only. The counter is not restarted.
- **LFSR step:**
  - `fb = lfsr[0] ^ lfsr[tap]`, where tap = short ? TAP_SHORT : TAP_LONG.
  - `lfsr = {fb, lfsr[LFSR_W-1:1]}`.
  - If `lfsr` is ever all-zero, the next step loads 1 (lockup guard).
- **Envelope:** runs on nLFO1 low.
  - If the start flag is set: clear it, decay = 15, divider = V.
  - Otherwise, when divider == 0: divider = V, then decay decrements if > 0, or reloads 15 if loop = 1.
  - When divider ≠ 0: divider decrements.
  - W_LEN sets the start flag.
- **Length counter:**
  - ENA = 0 forces lc = 0 every cycle and blocks loads.
  - W_LEN with ENA = 1 loads LC_VAL.
  - On nLFO2 low: decrement if lc ≠ 0 and halt = 0.
  - A load in the same cycle as nLFO2 wins; no decrement that cycle.
- **Output:**
  - vol = constant ? V : decay.
  - RND_OUT = (lfsr[0] == 0 && lc ≠ 0) ? vol : 0.
  - LC_ACT = (lc ≠ 0).
- **Simultaneous writes:** all strobes are independent and update their own fields in the same cycle.

## Timing
- **Reset values:** all registers 0 except lfsr = 1. tcnt = 0, lc = 0, decay = 0, start flag = 0. Outputs: RND_OUT = 0, LC_ACT = 0.
- **First step:** occurs on the first cycle after RES deasserts, because tcnt = 0.
- **Register writes:** visible in state at the ACLK edge where the strobe is high.
- **Outputs:** registered-state combinational, so RND_OUT reflects new state one edge after the cause.
- **LFO pulses:** act on the edge where they are sampled low. A pulse held low for N cycles counts N times; sources must issue single-cycle pulses.
- **RES mid-operation:** overrides all strobes and pulses that cycle; everything returns to reset values.

## Test plan
1. **Reset:** RES for 3 cycles → RND_OUT = 0, LC_ACT = 0, lfsr = 0x0001. Release → lfsr = 0x4000 one cycle later.
2. **Long mode, index 0:** ENA = 1; ctrl DB = 0x1F (constant 15); mode DB = 0x00; W_LEN with LC_VAL = 10.
   - LFSR steps every 2 cycles.
   - RND_OUT ∈ {0, 15}, following ~lfsr[0].
   - Sequence returns to its start state after 32767 steps.
3. **Short mode (DB = 0x80):** step-by-step match against the golden model over 200 steps. Counted period is 93 or 31, with no all-zero state.
4. **Length counter:**
   - LC_VAL = 3, halt = 0: three nLFO2 pulses → LC_ACT falls after the 3rd and RND_OUT = 0.
   - W_LEN coincident with nLFO2 → lc = LC_VAL.
   - ENA dropped → lc = 0 next edge.
5. **Envelope:** ctrl DB = 0x02, then W_LEN, then nLFO1 pulses.
   - decay = 15 after the 1st pulse, then −1 every 3 pulses, down to 0, and holds there.
   - With DB = 0x22 (loop), decay wraps 0 → 15.
6. **Direct period:** mode DB = 0x40, W_PLO = 5, W_PHI = 0 → step every 6 cycles.
   - A mid-count change to P = 1 applies only after the current reload.
   - RES mid-run restores all reset values.
